// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master front end for the FPGC5 MemoryUnit bus.
// Master 0 is the CPU and master 1 is a secondary master such as a DMA engine.
// Each master's one-cycle request is captured into its own latch. One request
// at a time is issued downstream. The result returns only to the master that
// issued the request.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both
// masters are pending. When it is undefined, master 0 always wins.
module bus_arbiter (
  input  logic        clk,
  input  logic        nreset,
  input  logic [26:0] m0_addr,
  input  logic [31:0] m0_data,
  input  logic        m0_we,
  input  logic        m0_start,
  output logic [31:0] m0_q,
  output logic        m0_done,
  input  logic [26:0] m1_addr,
  input  logic [31:0] m1_data,
  input  logic        m1_we,
  input  logic        m1_start,
  output logic [31:0] m1_q,
  output logic        m1_done,
  output logic [26:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        bus_start,
  input  logic [31:0] bus_q,
  input  logic        bus_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_grant;   // master that owns the outstanding transaction

  logic        r_pend0;
  logic        r_pend1;
  logic [26:0] r_addr0;
  logic [26:0] r_addr1;
  logic [31:0] r_data0;
  logic [31:0] r_data1;
  logic        r_we0;
  logic        r_we1;

  logic        w_clr0;
  logic        w_clr1;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_sel_valid;
  logic        w_sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic        r_rr_ptr;  // master preferred at the next contended grant
`endif

  // Clear and accept conditions for the request latches
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_clr0 = 1'b0;
    w_clr1 = 1'b0;
    if (r_state == S_WAIT && bus_done) begin
      w_clr0 = ~r_grant;
      w_clr1 =  r_grant;
    end
    // A start in the completion cycle of the same master is accepted. The set
    // takes precedence over the clear, so that master can chain its requests.
    w_acc0 = m0_start && (!r_pend0 || w_clr0);
    w_acc1 = m1_start && (!r_pend1 || w_clr1);
  end

  // Arbitration among the pending requests
  always_comb begin
    w_sel_valid = r_pend0 | r_pend1;
`ifdef ARB_ROUND_ROBIN_EN
    if (r_pend0 && r_pend1) w_sel = r_rr_ptr;
    else                    w_sel = ~r_pend0;
`else
    w_sel = ~r_pend0;
`endif
  end

  // Per-master request latches: capture on an accepted start, drop on completion
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // The data latches are reset along with the pend bits, so an abandoned
      // request leaves no stale contents behind.
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_we0   <= 1'b0;
      r_we1   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every
      // flop samples values from before the edge.
      if (w_acc0) begin
        r_pend0 <= 1'b1;
        r_addr0 <= m0_addr;
        r_data0 <= m0_data;
        r_we0   <= m0_we;
      end else if (w_clr0) begin
        r_pend0 <= 1'b0;
      end
      if (w_acc1) begin
        r_pend1 <= 1'b1;
        r_addr1 <= m1_addr;
        r_data1 <= m1_data;
        r_we1   <= m1_we;
      end else if (w_clr1) begin
        r_pend1 <= 1'b0;
      end
    end
  end

  // Issue FSM with registered bus and completion outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      bus_we    <= 1'b0;
      bus_start <= 1'b0;
      m0_q      <= '0;
      m1_q      <= '0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_ptr  <= 1'b0;
`endif
    end else begin
      bus_start <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_grant   <= w_sel;
            bus_addr  <= w_sel ? r_addr1 : r_addr0;
            bus_data  <= w_sel ? r_data1 : r_data0;
            bus_we    <= w_sel ? r_we1   : r_we0;
            bus_start <= 1'b1;  // high for exactly the ISSUE cycle
            r_state   <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr  <= ~w_sel;
`endif
          end
        end
        S_ISSUE: begin
          // A bus_done seen here belongs to no transaction of ours.
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus_done) begin
            if (r_grant) begin
              m1_q    <= bus_q;
              m1_done <= 1'b1;
            end else begin
              m0_q    <= bus_q;
              m0_done <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. It uses a per-master request scoreboard
// and a small arbitration model. Expected issues are queued when a master
// request is driven. They are popped and compared when the bus issues.
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        nreset;
  logic [26:0] m0_addr, m1_addr, bus_addr;
  logic [31:0] m0_data, m1_data, bus_data;
  logic        m0_we, m1_we, bus_we;
  logic        m0_start, m1_start, bus_start;
  logic [31:0] m0_q, m1_q, bus_q;
  logic        m0_done, m1_done, bus_done;

  bus_arbiter dut (
    .clk(clk), .nreset(nreset),
    .m0_addr(m0_addr), .m0_data(m0_data), .m0_we(m0_we), .m0_start(m0_start),
    .m0_q(m0_q), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_data(m1_data), .m1_we(m1_we), .m1_start(m1_start),
    .m1_q(m1_q), .m1_done(m1_done),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .bus_start(bus_start),
    .bus_q(bus_q), .bus_done(bus_done)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [26:0] addr;
    logic [31:0] data;
    logic        we;
  } req_t;

  req_t        exp0[$];
  req_t        exp1[$];
  int          m_ptr;
  logic [31:0] q0_m, q1_m;
  int          checks, errors;
  int          n_done0, n_done1, n_bstart;
  logic [26:0] seq_addr;
  logic [31:0] seq_q;

  // Output event counters
  always @(negedge clk) begin
    if (m0_done)   n_done0  <= n_done0 + 1;
    if (m1_done)   n_done1  <= n_done1 + 1;
    if (bus_start) n_bstart <= n_bstart + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [26:0] a, input logic [31:0] d, input logic w, input bit push);
    req_t r;
    m0_addr = a; m0_data = d; m0_we = w; m0_start = 1'b1;
    r.addr = a; r.data = d; r.we = w;
    if (push) exp0.push_back(r);
  endtask

  task automatic drive1(input logic [26:0] a, input logic [31:0] d, input logic w, input bit push);
    req_t r;
    m1_addr = a; m1_data = d; m1_we = w; m1_start = 1'b1;
    r.addr = a; r.data = d; r.we = w;
    if (push) exp1.push_back(r);
  endtask

  task automatic tick_clear();
    sync();
    m0_start = 1'b0;
    m1_start = 1'b0;
    bus_done = 1'b0;
  endtask

  // Wait for an issue, compare it with the model, answer after lat cycles and
  // check the completion. Optionally the served master re-requests in the
  // bus_done cycle.
  task automatic serve(input int exp_wait, input logic [31:0] qv, input int lat,
                       input bit rereq, output int got_m);
    int   n;
    int   g;
    bit   seen;
    req_t r;
    got_m = -1;
    seen  = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("bus_start_seen", 64'(seen), 64'd1);
    if (!seen) return;
    if (exp_wait >= 0) check("issue_latency", 64'(n), 64'(exp_wait));
    if (exp0.size() > 0 && exp1.size() > 0) g = RR ? m_ptr : 0;
    else if (exp0.size() > 0)               g = 0;
    else if (exp1.size() > 0)               g = 1;
    else begin
      check("unexpected_issue", 64'd1, 64'd0);
      return;
    end
    if (RR) m_ptr = 1 - g;
    r = (g == 0) ? exp0.pop_front() : exp1.pop_front();
    check("bus_addr", 64'(bus_addr), 64'(r.addr));
    check("bus_we",   64'(bus_we),   64'(r.we));
    check("bus_data", 64'(bus_data), 64'(r.data));
    for (int i = 0; i < lat; i++) sync();
    bus_done = 1'b1;
    bus_q    = qv;
    if (rereq) begin
      seq_addr = seq_addr + 27'd1;
      if (g == 0) drive0(seq_addr, 32'h0, 1'b0, 1'b1);
      else        drive1(seq_addr, 32'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    check("no_back2back", 64'(bus_start), 64'd0);
    check("addr_hold",    64'(bus_addr),  64'(r.addr));
    tick_clear();
    @(negedge clk);
    got_m = m1_done ? 1 : (m0_done ? 0 : -1);
    check("done_master", 64'(got_m), 64'(g));
    if (g == 0) begin
      q0_m = qv;
      check("m1_done_quiet", 64'(m1_done), 64'd0);
    end else begin
      q1_m = qv;
      check("m0_done_quiet", 64'(m0_done), 64'd0);
    end
    check("m0_q", 64'(m0_q), 64'(q0_m));
    check("m1_q", 64'(m1_q), 64'(q1_m));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bus"}, {bus_addr, bus_data, bus_we, bus_start},
          64'd0);
    check({tag, "_m0"},  {31'd0, m0_done, m0_q}, 64'd0);
    check({tag, "_m1"},  {31'd0, m1_done, m1_q}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gm;
    int b0, b1, bs;
    int pattern[6];
    bit seen;

    checks = 0; errors = 0;
    n_done0 = 0; n_done1 = 0; n_bstart = 0;
    m_ptr = 0; q0_m = '0; q1_m = '0;
    seq_addr = 27'h100; seq_q = 32'hA000_0000;
    nreset = 1'b0;
    m0_addr = '0; m0_data = '0; m0_we = 1'b0; m0_start = 1'b0;
    m1_addr = '0; m1_data = '0; m1_we = 1'b0; m1_start = 1'b0;
    bus_q = '0; bus_done = 1'b0;
    repeat (3) sync();
    nreset = 1'b1;
    sync();
    check_outputs_zero("reset");

    // Single read from master 0
    drive0(27'h0000010, 32'h0, 1'b0, 1'b1);
    tick_clear();
    serve(1, 32'hDEADBEEF, 3, 1'b0, gm);

    // Simultaneous starts: M0 write wins, M1 issues two cycles after M0's bus_done
    sync();
    drive0(27'h1, 32'h11, 1'b1, 1'b1);
    drive1(27'h2, 32'h0, 1'b0, 1'b1);
    tick_clear();
    serve(1, 32'h0000_1111, 2, 1'b0, gm);
    serve(0, 32'h2222_2222, 1, 1'b0, gm);

    // Fairness under continuous contention
    for (int i = 0; i < 6; i++) pattern[i] = RR ? (i % 2) : 0;
    sync();
    drive0(27'h40, 32'h0, 1'b0, 1'b1);
    drive1(27'h80, 32'h0, 1'b0, 1'b1);
    tick_clear();
    for (int i = 0; i < 6; i++) begin
      seq_q = seq_q + 32'd1;
      serve(-1, seq_q, 1, 1'b1, gm);
      check("fair_grant", 64'(gm), 64'(pattern[i]));
    end
    for (int i = 0; i < 4 && (exp0.size() + exp1.size()) > 0; i++) begin
      seq_q = seq_q + 32'd1;
      serve(0, seq_q, 1, 1'b0, gm);
    end
    check("drain_empty", 64'(exp0.size() + exp1.size()), 64'd0);

    // Protocol violation: second M1 start while pending is dropped
    sync();
    b1 = n_done1; bs = n_bstart;
    drive1(27'h4, 32'h0, 1'b0, 1'b1);
    tick_clear();
    drive1(27'h5, 32'h0, 1'b0, 1'b0);
    tick_clear();
    serve(0, 32'h4444_4444, 2, 1'b0, gm);
    repeat (6) sync();
    check("viol_issues", 64'(n_bstart - bs), 64'd1);
    check("viol_dones",  64'(n_done1 - b1),  64'd1);

    // Stray bus_done in IDLE
    b0 = n_done0; b1 = n_done1; bs = n_bstart;
    bus_done = 1'b1;
    bus_q    = 32'h1234_5678;
    tick_clear();
    repeat (4) sync();
    check("stray_dones",  64'(n_done0 + n_done1 - b0 - b1), 64'd0);
    check("stray_issues", 64'(n_bstart - bs), 64'd0);
    check("stray_m0_q",   64'(m0_q), 64'(q0_m));
    check("stray_m1_q",   64'(m1_q), 64'(q1_m));

    // Reset during WAIT abandons the transaction
    drive0(27'h30, 32'h0, 1'b0, 1'b0);
    tick_clear();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus_start;
    end
    check("rst_issue_seen", 64'(seen), 64'd1);
    sync();
    sync();
    b0 = n_done0; b1 = n_done1;
    nreset = 1'b0;
    #2;
    check_outputs_zero("async_reset");
    sync();
    bus_done = 1'b1;
    bus_q    = 32'hBAD0_BAD0;
    tick_clear();
    nreset = 1'b1;
    m_ptr = 0; q0_m = '0; q1_m = '0;
    exp0.delete(); exp1.delete();
    repeat (3) sync();
    check_outputs_zero("post_reset");
    check("rst_no_done", 64'(n_done0 + n_done1 - b0 - b1), 64'd0);
    drive0(27'h50, 32'h0, 1'b0, 1'b1);
    tick_clear();
    serve(1, 32'hCAFE_F00D, 1, 1'b0, gm);

    repeat (2) sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
